// File: rtl/load_store_unit.sv
// load_store_unit
//   Byte-addressed load/store unit between a RISC-V style core and a
//   word-wide synchronous data memory. The unit handles one access at a time.
//   Sub-word stores use read-modify-write, so the memory needs no byte enables.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   req_valid/ready core request handshake; ready only while idle
//   req_we          1 = store, 0 = load
//   req_funct3      RISC-V width code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr        byte address
//   req_wdata       store data, right-justified
//   rsp_valid       one-cycle completion pulse
//   rsp_rdata       formatted load data (0 for stores and errors)
//   rsp_err         misaligned access or illegal funct3
//   mem_A           word-aligned byte address to memory
//   mem_WE, mem_WD  memory write enable / write data (WD is 0 when WE is 0)
//   mem_RD          memory read data, valid one cycle after mem_A
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_A,
    output logic        mem_WE,
    output logic [31:0] mem_WD,
    input  logic [31:0] mem_RD
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ISSUE    = 3'd1;
    localparam logic [2:0] CAPT     = 3'd2;
    localparam logic [2:0] MERGE_WR = 3'd3;
    localparam logic [2:0] RESP     = 3'd4;

    localparam logic [2:0] F3_W = 3'b010;

    logic [2:0]  state;
    logic [31:0] addr_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    // Illegal width code or an address not aligned to the access size.
    function automatic logic access_err(input logic we, input logic [2:0] f3,
                                        input logic [1:0] a);
        logic bad_f3;
        logic misalign;
        bad_f3   = we ? (f3 >= 3'b011) : (f3 == 3'b011 || f3[2:1] == 2'b11);
        misalign = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
        return bad_f3 || misalign;
    endfunction

    // Extract and extend the addressed byte/half from a memory word.
    function automatic logic [31:0] format_load(input logic [2:0] f3,
                                                input logic [1:0] a,
                                                input logic [31:0] word);
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        logic signed [31:0] r;
        b_s = word[{a, 3'b000} +: 8];
        h_s = word[{a[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = 32'(b_s);
            3'b001:  r = 32'(h_s);
            3'b100:  r = {24'd0, b_s};
            3'b101:  r = {16'd0, h_s};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed byte/half of the old word with store data.
    function automatic logic [31:0] merge_store(input logic [2:0] f3,
                                                input logic [1:0] a,
                                                input logic [31:0] old,
                                                input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        if (f3[0])
            r[{a[1], 4'b0000} +: 16] = wd[15:0];
        else
            r[{a, 3'b000} +: 8] = wd[7:0];
        return r;
    endfunction

    // Control state, address and response registers (reset to zero).
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        rdata_q <= '0;
                        err_q   <= access_err(req_we, req_funct3, req_addr[1:0]);
                        // An erroneous access skips the memory entirely.
                        state   <= access_err(req_we, req_funct3, req_addr[1:0]) ? RESP : ISSUE;
                    end
                end
                ISSUE: begin
                    if (we_q && funct3_q == F3_W)
                        state <= RESP;
                    else if (we_q)
                        state <= MERGE_WR;
                    else
                        state <= CAPT;
                end
                CAPT: begin
                    rdata_q <= format_load(funct3_q, addr_q[1:0], mem_RD);
                    state   <= RESP;
                end
                MERGE_WR: state <= RESP;
                RESP:     state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    // Request attributes; only meaningful while an access is in flight.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            wdata_q  <= req_wdata;
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_A     = {addr_q[31:2], 2'b00};
    assign mem_WE    = (state == ISSUE && we_q && funct3_q == F3_W) || (state == MERGE_WR);

    always_comb begin
        mem_WD = '0;
        if (state == ISSUE && we_q && funct3_q == F3_W)
            mem_WD = wdata_q;
        else if (state == MERGE_WR)
            mem_WD = merge_store(funct3_q, addr_q[1:0], mem_RD, wdata_q);
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters: none; all widths are fixed at 32-bit data, 32-bit byte address and 3-bit funct3.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 req_valid  in  1  core presents an access.
REQ-005 req_ready  out  1  LSU accepts an access; accept = req_valid && req_ready.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RISC-V width code: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-justified.
REQ-010 rsp_valid  out  1  one-cycle completion pulse.
REQ-011 rsp_rdata  out  32  formatted load data; 0 for stores and errors.
REQ-012 rsp_err  out  1  misaligned access or illegal funct3; valid with rsp_valid.
REQ-013 mem_A  out  32  word-aligned byte address to data memory, {addr_q[31:2],2'b00}.
REQ-014 mem_WE  out  1  memory write enable.
REQ-015 mem_WD  out  32  memory write data.
REQ-016 mem_RD  in  32  memory read data, registered by memory one cycle after mem_A.

Function
REQ-017 The LSU SHALL implement FSM states IDLE, ISSUE, CAPT, MERGE_WR, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; at accept, addr, we, funct3 and wdata SHALL be latched.
REQ-019 Error check at accept: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0, load funct3 in {011,110,111}, store funct3 >= 011; on error the LSU SHALL go IDLE->RESP with no memory access.
REQ-020 Load path, accept in cycle T: IDLE->ISSUE (T+1, mem_A driven, mem_WE=0)->CAPT (T+2, mem_RD sampled and formatted into rsp_rdata)->RESP (T+3).
REQ-021 Load formatting: byte/halfword selected by addr_q[1:0]/addr_q[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-022 SW path: ISSUE (T+1) with mem_WE=1, mem_WD=wdata->RESP (T+2).
REQ-023 SB/SH path (read-modify-write): ISSUE (T+1) read->MERGE_WR (T+2) with mem_WE=1, mem_WD = mem_RD with the selected byte/half replaced by wdata[7:0]/wdata[15:0]->RESP (T+3).
REQ-024 RESP SHALL assert rsp_valid for exactly one cycle and then return to IDLE; there is no response backpressure.
REQ-025 mem_WE SHALL be 1 only in ISSUE for SW and in MERGE_WR; otherwise it is 0, and mem_WD SHALL be 0 whenever mem_WE=0.
REQ-026 req_valid outside IDLE SHALL be ignored and SHALL NOT disturb latched state.
REQ-027 Back-to-back requests: the earliest next accept is the cycle after RESP.
REQ-028 Address bits [31:2] SHALL pass through unchanged; wrap-around is the memory's concern.

Reset
REQ-029 While rst=1 at a posedge, the state SHALL become IDLE; rsp_valid, rsp_err, rsp_rdata, mem_WE, mem_A and mem_WD SHALL become 0; req_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-030 Reset mid-operation SHALL abort the access with no response, and mem_WE SHALL be 0 from the cycle after the reset edge; a write already performed is not undone.

Verification
REQ-031 Memory word 0 = 0x00000028; LW addr 0x0 accepted at T -> rsp_valid at T+3, rsp_rdata 0x00000028, rsp_err 0, mem_WE never 1.
REQ-032 SW addr 0x8, wdata 0xDEADBEEF -> at T+1 mem_WE=1, mem_A=0x8, mem_WD=0xDEADBEEF; rsp_valid at T+2; a following LW 0x8 returns 0xDEADBEEF.
REQ-033 SB addr 0x9, wdata 0x000000AA over 0xDEADBEEF -> at T+2 mem_WE=1, mem_WD=0xDEADAAEF; LB 0x9 returns 0xFFFFFFAA; LBU 0x9 returns 0x000000AA.
REQ-034 SH addr 0x6, wdata 0x00008001 over word 0x4 = 0 -> write 0x80010000; LH 0x6 returns 0xFFFF8001; LHU 0x6 returns 0x00008001.
REQ-035 LW addr 0x2 and load funct3 011 -> rsp_valid at T+1, rsp_err 1, rsp_rdata 0, no mem_WE.
REQ-036 SB accepted at T with rst=1 during T+1 -> mem_WE never 1, no rsp_valid, req_ready=1 in the cycle after rst drops.
